// File: rtl/reg_bank_avalon.sv
// Avalon-MM register bank: byte-enabled control registers, a W1C rising-edge event
// register with an interrupt mask, and a fixed one-cycle registered read path.
module reg_bank_avalon #(
    parameter int                    NUM_REGS    = 4,
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    localparam int                   BE_W        = DATA_WIDTH / 8,
    localparam int                   ADDR_W      = $clog2(NUM_REGS + 3)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           chipselect,
    input  logic [ADDR_W-1:0]              address,
    input  logic                           write,
    input  logic                           read,
    input  logic [DATA_WIDTH-1:0]          writedata,
    input  logic [BE_W-1:0]                byteenable,
    output logic [DATA_WIDTH-1:0]          readdata,
    output logic                           readdatavalid,
    input  logic [DATA_WIDTH-1:0]          event_in,
    output logic [NUM_REGS*DATA_WIDTH-1:0] Q_export,
    output logic [NUM_REGS-1:0]            wr_strobe,
    output logic                           irq
);

    localparam logic [ADDR_W-1:0] EVENT_ADDR = ADDR_W'(NUM_REGS);
    localparam logic [ADDR_W-1:0] MASK_ADDR  = ADDR_W'(NUM_REGS + 1);
    localparam logic [ADDR_W-1:0] RAW_ADDR   = ADDR_W'(NUM_REGS + 2);

    logic                           wr_en;
    logic                           rd_en;
    logic [DATA_WIDTH-1:0]          be_mask;
    logic [NUM_REGS*DATA_WIDTH-1:0] ctrl_flat;
    logic [NUM_REGS-1:0]            wr_strobe_reg;
    logic [DATA_WIDTH-1:0]          event_reg;
    logic [DATA_WIDTH-1:0]          event_next;
    logic [DATA_WIDTH-1:0]          irq_mask_reg;
    logic [DATA_WIDTH-1:0]          event_in_d_reg;
    logic [DATA_WIDTH-1:0]          readdata_reg;
    logic [DATA_WIDTH-1:0]          readdata_next;
    logic                           readdatavalid_reg;

    assign wr_en = chipselect & write;
    assign rd_en = chipselect & read;

    genvar gi;
    generate
        for (gi = 0; gi < BE_W; gi++) begin : g_be
            assign be_mask[gi*8 +: 8] = {8{byteenable[gi]}};
        end

        // Each control register owns its storage and strobe bit so nothing is multiply driven.
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_ctrl
            logic                  hit;
            logic [DATA_WIDTH-1:0] ctrl_reg;
            logic                  strobe_reg;

            assign hit = wr_en && (address == ADDR_W'(gi));

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    ctrl_reg   <= RESET_VALUE;
                    strobe_reg <= 1'b0;
                end else begin
                    strobe_reg <= hit;
                    if (hit)
                        ctrl_reg <= (ctrl_reg & ~be_mask) | (writedata & be_mask);
                end
            end

            assign ctrl_flat[gi*DATA_WIDTH +: DATA_WIDTH] = ctrl_reg;
            assign wr_strobe_reg[gi] = strobe_reg;
        end
    endgenerate

    // Set wins over clear: the edge term is OR'd in after the W1C mask.
    always_comb begin
        event_next = event_reg;
        if (wr_en && address == EVENT_ADDR)
            event_next = event_reg & ~(writedata & be_mask);
        event_next = event_next | (event_in & ~event_in_d_reg);
    end

    // Reads see the pre-write register contents.
    always_comb begin
        readdata_next = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (address == ADDR_W'(i))
                readdata_next = ctrl_flat[i*DATA_WIDTH +: DATA_WIDTH];
        end
        if (address == EVENT_ADDR) readdata_next = event_reg;
        if (address == MASK_ADDR)  readdata_next = irq_mask_reg;
        if (address == RAW_ADDR)   readdata_next = event_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            event_reg         <= '0;
            irq_mask_reg      <= '0;
            event_in_d_reg    <= '0;
            readdata_reg      <= '0;
            readdatavalid_reg <= 1'b0;
        end else begin
            event_reg         <= event_next;
            event_in_d_reg    <= event_in;
            readdatavalid_reg <= rd_en;
            if (wr_en && address == MASK_ADDR)
                irq_mask_reg <= (irq_mask_reg & ~be_mask) | (writedata & be_mask);
            if (rd_en)
                readdata_reg <= readdata_next;
        end
    end

    assign Q_export      = ctrl_flat;
    assign wr_strobe     = wr_strobe_reg;
    assign readdata      = readdata_reg;
    assign readdatavalid = readdatavalid_reg;
    assign irq           = |(event_reg & irq_mask_reg);

endmodule

// File: doc/reg_bank_avalon.md
REG_BANK_AVALON -- requirements
Module: reg_bank_avalon

Interface
REQ-001 SHALL have parameter NUM_REGS, default 4, number of read/write control registers, legal range 1..16.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register width, multiple of 8, legal range 8..64.
REQ-003 SHALL have parameter RESET_VALUE, default 0, reset value of every control register.
REQ-004 SHALL derive localparams BE_W = DATA_WIDTH/8 and ADDR_W = clog2(NUM_REGS+3).
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port chipselect, input, 1, Avalon-MM slave select.
REQ-008 SHALL have port address, input, ADDR_W, word address.
REQ-009 SHALL have ports write and read, input, 1 each, Avalon-MM strobes.
REQ-010 SHALL have port writedata, input, DATA_WIDTH, write data.
REQ-011 SHALL have port byteenable, input, BE_W, byte lane enables.
REQ-012 SHALL have port readdata, output, DATA_WIDTH, registered read data.
REQ-013 SHALL have port readdatavalid, output, 1, read data qualifier.
REQ-014 SHALL have port event_in, input, DATA_WIDTH, event sources, synchronous to clk.
REQ-015 SHALL have port Q_export, output, NUM_REGS*DATA_WIDTH; register i sits at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-016 SHALL have port wr_strobe, output, NUM_REGS, per-register update pulse.
REQ-017 SHALL have port irq, output, 1, level interrupt.

Function
REQ-018 SHALL use this address map: 0..NUM_REGS-1 = CTRL[i] (RW); NUM_REGS = EVENT (W1C); NUM_REGS+1 = IRQ_MASK (RW); NUM_REGS+2 = EVENT_RAW (RO, current event_in).
REQ-019 SHALL accept a write when chipselect=1 and write=1; per lane b, bits [8b+7:8b] are updated only if byteenable[b]=1.
REQ-020 SHALL make a CTRL/IRQ_MASK write visible on Q_export and readback in the cycle after the accepting edge.
REQ-021 SHALL pulse wr_strobe[i] for exactly one cycle, coincident with the new CTRL[i] value appearing, for any accepted write to CTRL[i] (including byteenable=0).
REQ-022 SHALL detect rising edges on event_in with a one-cycle-delayed copy: edge[k] = event_in[k] & ~event_in_d[k].
REQ-023 SHALL set EVENT[k] on edge[k] and hold it until cleared.
REQ-024 SHALL clear EVENT[k] when a write to EVENT has writedata[k]=1 with its lane enabled; 0 bits have no effect.
REQ-025 SHALL give set priority when an edge and a clear hit the same bit in the same cycle (bit stays 1).
REQ-026 SHALL drive irq = |(EVENT & IRQ_MASK), decoded from register outputs only (glitch-free, no input path).
REQ-027 SHALL, on chipselect=1 and read=1, register readdata and assert readdatavalid for exactly one cycle one edge later (fixed latency 1, back-to-back reads every cycle allowed).
REQ-028 SHALL return the pre-write value of the target register when read and write are asserted in the same cycle; both operations are performed.
REQ-029 SHALL return 0 for reads of unmapped addresses (> NUM_REGS+2) and ignore writes to them and to EVENT_RAW, with no wr_strobe.
REQ-030 SHALL hold readdata at its last value when readdatavalid=0.

Reset
REQ-031 SHALL, on reset assertion, immediately (asynchronously) set CTRL[*]=RESET_VALUE, EVENT=0, IRQ_MASK=0, event_in_d=0, readdata=0, readdatavalid=0, wr_strobe=0, irq=0.
REQ-032 SHALL discard any transaction in flight at reset assertion; a read pending in the latency stage produces no readdatavalid.
REQ-033 SHALL register a rising edge on the first cycle after reset release only if event_in is 1 then (event_in_d reset to 0).

Verification
REQ-034 Byte-enable write: NUM_REGS=4, DATA_WIDTH=32, write CTRL[2]=0xAABBCCDD be=0xF, then 0x11223344 be=0x5 -> Q_export[95:64]=0xAA22CC44, wr_strobe=0b0100 for one cycle each time.
REQ-035 Read latency: read addr 2 in cycle N, addr 1 in N+1 -> readdatavalid=1 in N+1, N+2 with 0xAA22CC44, then RESET_VALUE.
REQ-036 Event/irq: IRQ_MASK=0x1, event_in bit0 0->1 -> EVENT=0x1, irq=1; write EVENT 0x1 -> EVENT=0, irq=0; holding event_in=1 does not re-set it.
REQ-037 Set-vs-clear race: edge on bit3 in the same cycle as a W1C of 0x8 -> EVENT[3]=1 afterwards.
REQ-038 Unmapped/RO: write 0xFFFFFFFF to addr 7 and to EVENT_RAW -> no state change, no wr_strobe; read addr 7 -> 0x00000000.
REQ-039 Async reset mid-read: assert reset between read edge and data cycle -> readdatavalid stays 0, all outputs reset values without a clock edge.
